// File: rtl/ru_vec_if.sv
// Stream interface for ru_vec.
// slave  : the ru_vec side. It takes input beats and mode bits and drives the result stream and the row sum.
// master : the producer/consumer side, such as a testbench or the surrounding datapath.
// Input beat  : i_valid/o_ready handshake, with i_last, i_sel_mult, i_sel_mux, i_in0 and i_in1.
// Output beat : o_valid/i_ready handshake, with o_last, o_out0 and o_out1.
// Row sum     : o_sum, qualified by the o_sum_valid pulse.
interface ru_vec_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 32
);
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_last;
  logic                   i_sel_mult;
  logic                   i_sel_mux;
  logic [LANES*ACC_W-1:0] i_in0;
  logic [LANES*DW-1:0]    i_in1;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_last;
  logic [LANES*DW-1:0]    o_out0;
  logic [LANES*DW-1:0]    o_out1;
  logic [ACC_W-1:0]       o_sum;
  logic                   o_sum_valid;

  modport slave (
    input  i_valid, i_last, i_sel_mult, i_sel_mux, i_in0, i_in1, i_ready,
    output o_ready, o_valid, o_last, o_out0, o_out1, o_sum, o_sum_valid
  );

  modport master (
    output i_valid, i_last, i_sel_mult, i_sel_mux, i_in0, i_in1, i_ready,
    input  o_ready, o_valid, o_last, o_out0, o_out1, o_sum, o_sum_valid
  );
endinterface

// File: rtl/ru_vec.sv
// ru_vec: multi-lane softmax reduction unit.
// Each lane computes s = (x - m), optionally scaled by log2(e), and then the 2^s approximation.
// The pipeline has three stages with a full-pipeline stall, and it keeps a saturating row sum of o_out1.
// Ports:
//   i_clk   : rising-edge clock.
//   i_rst_n : synchronous reset, active-low.
//   i_en    : global enable. When low, all state is frozen.
//   bus     : ru_vec_if slave port. It carries the input beats, the output beats and the row sum.
module ru_vec #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LOG2E = 1477
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_en,
  ru_vec_if.slave bus
);
  localparam int unsigned PW = 2 * DW;
  localparam logic signed [DW-1:0]    DW_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    DW_MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW-1:0]    L2E     = PW'(LOG2E);
  localparam logic [DW+FRAC:0]        POW_LIM = {(FRAC+1)'(0), 1'b0, {(DW-1){1'b1}}};

  // Clamp an ACC_W-wide lane input to DW bits.
  function automatic logic signed [DW-1:0] sat_in(input logic [ACC_W-1:0] x);
    if (x[ACC_W-1:DW-1] == {(ACC_W-DW+1){x[ACC_W-1]}}) return x[DW-1:0];
    return x[ACC_W-1] ? DW_MIN : DW_MAX;
  endfunction

  // Compute xs - m at DW+1 bits and then saturate the result to DW bits.
  function automatic logic signed [DW-1:0] sub_sat(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [DW:0] d;
    d = (DW+1)'(a) - (DW+1)'(b);
    if (d[DW] == d[DW-1]) return d[DW-1:0];
    return d[DW] ? DW_MIN : DW_MAX;
  endfunction

  // Compute (d * LOG2E) >>> FRAC on the full-width product.
  // The shift is arithmetic, so it rounds toward minus infinity.
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] d);
    logic signed [PW-1:0] p;
    p = PW'(d) * L2E;
    p = p >>> FRAC;
    if (p[PW-1:DW-1] == {(PW-DW+1){p[PW-1]}}) return p[DW-1:0];
    return p[PW-1] ? DW_MIN : DW_MAX;
  endfunction

  // Approximate 2^s as (1.f) shifted by floor(s).
  // Large positive exponents saturate to DW_MAX. Very negative exponents flush to zero.
  function automatic logic signed [DW-1:0] pow2(input logic signed [DW-1:0] s);
    int            n;
    logic [FRAC:0] mant;
    logic [DW+FRAC:0] wide;
    n    = int'(s >>> FRAC);
    mant = {1'b1, s[FRAC-1:0]};
    if (n >= 0) begin
      if (n >= int'(DW)) return DW_MAX;
      wide = (DW+FRAC+1)'(mant) << n;
      if (wide > POW_LIM) return DW_MAX;
      return wide[DW-1:0];
    end
    if (-n >= int'(DW)) return '0;
    return DW'(mant >> (-n));
  endfunction

  logic                   stall, advance, out_fire;
  logic                   s1_v, s1_last, s1_mult, s1_mux;
  logic signed [DW-1:0]   s1_d [LANES];
  logic                   s2_v, s2_last, s2_mux;
  logic signed [DW-1:0]   s2_s [LANES];
  logic                   out_v, out_last;
  logic [LANES*DW-1:0]    out0_q, out1_q;
  logic signed [ACC_W-1:0] acc_q, acc_next, sum_q;
  logic                   sum_v;

  logic signed [DW-1:0]   d_c [LANES];
  logic signed [DW-1:0]   s_c [LANES];
  logic [LANES*DW-1:0]    out0_c, out1_c;
  logic signed [ACC_W:0]  lane_sum, acc_ext;

  assign stall       = out_v & ~bus.i_ready;
  assign advance     = i_en & ~stall;
  assign out_fire    = i_en & out_v & bus.i_ready;
  assign bus.o_ready = i_rst_n & advance;

  assign bus.o_valid     = out_v;
  assign bus.o_last      = out_last;
  assign bus.o_out0      = out0_q;
  assign bus.o_out1      = out1_q;
  assign bus.o_sum       = sum_q;
  assign bus.o_sum_valid = sum_v;

  // Per-lane datapath for each stage. The result is the next-state value of the stage register.
  always_comb begin
    d_c    = '{default: '0};
    s_c    = '{default: '0};
    out0_c = '0;
    out1_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      d_c[k] = sub_sat(sat_in(bus.i_in0[k*ACC_W +: ACC_W]), $signed(bus.i_in1[k*DW +: DW]));
      s_c[k] = s1_mult ? scale(s1_d[k]) : s1_d[k];
      out0_c[k*DW +: DW] = s2_s[k];
      out1_c[k*DW +: DW] = s2_mux ? pow2(s2_s[k]) : s2_s[k];
    end
  end

  // Add this beat's lane total to the row accumulator, saturating to ACC_W.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane_sum = lane_sum + (ACC_W+1)'($signed(out1_q[k*DW +: DW]));
    end
    acc_ext = (ACC_W+1)'(acc_q) + lane_sum;
    if (acc_ext[ACC_W] == acc_ext[ACC_W-1]) acc_next = acc_ext[ACC_W-1:0];
    else                                    acc_next = acc_ext[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // Pipeline registers, output registers and the row accumulator.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_v     <= 1'b0;
      s1_last  <= 1'b0;
      s1_mult  <= 1'b0;
      s1_mux   <= 1'b0;
      s1_d     <= '{default: '0};
      s2_v     <= 1'b0;
      s2_last  <= 1'b0;
      s2_mux   <= 1'b0;
      s2_s     <= '{default: '0};
      out_v    <= 1'b0;
      out_last <= 1'b0;
      out0_q   <= '0;
      out1_q   <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      sum_v    <= 1'b0;
    end else if (i_en) begin
      if (!stall) begin
        s1_v     <= bus.i_valid;
        s1_last  <= bus.i_last;
        s1_mult  <= bus.i_sel_mult;
        s1_mux   <= bus.i_sel_mux;
        s1_d     <= d_c;
        s2_v     <= s1_v;
        s2_last  <= s1_last;
        s2_mux   <= s1_mux;
        s2_s     <= s_c;
        out_v    <= s2_v;
        out_last <= s2_last;
        out0_q   <= out0_c;
        out1_q   <= out1_c;
      end
      sum_v <= out_fire & out_last;
      if (out_fire) begin
        if (out_last) begin
          // Close the row. The next beat then starts a fresh sum.
          sum_q <= acc_next;
          acc_q <= '0;
        end else begin
          acc_q <= acc_next;
        end
      end
    end else begin
      sum_v <= 1'b0;
    end
  end
endmodule

// File: doc/ru_vec.md
Name: ru_vec

Overview:
- Parametrised, multi-lane successor to the softmax reduction unit in the tree-based softmax approximation datapath.
- Each lane computes a scaled difference `s = (x - m)`, optionally multiplied by log2(e), and the base-2 exponent approximation `2^s`.
- Adds a valid/ready handshake with full-pipeline stall, per-beat mode capture, and a per-row saturating sum of the `2^s` outputs for the softmax denominator.
- Sits between the max-reduction tree and the divider/normaliser.

Parameters:
- LANES, 4, number of parallel lanes.
- DW, 16, signed fixed-point data width.
- FRAC, 10, fractional bits (Q5.10 at defaults).
- ACC_W, 32, width of the `i_in0` lane inputs and of `o_sum`.
- LOG2E, 1477, log2(e) in Q.FRAC.

Ports:
- `i_clk  in  1` — clock, all logic on rising edge.
- `i_rst_n  in  1` — reset, synchronous, active-low.
- `i_en  in  1` — global enable; 0 freezes all state.
- `i_sel_mult  in  1` — 1: multiply the difference by LOG2E.
- `i_sel_mux  in  1` — 1: `o_out1` is 2^s; 0: `o_out1` = s.
- `i_valid  in  1` — input beat valid.
- `o_ready  out  1` — input beat accepted when `i_valid & o_ready`.
- `i_last  in  1` — last beat of a softmax row.
- `i_in0  in  LANES*ACC_W` — per-lane signed x, Q.FRAC; lane k at bits [k*ACC_W +: ACC_W].
- `i_in1  in  LANES*DW` — per-lane signed m (row max), Q.FRAC.
- `o_valid  out  1` — output beat valid.
- `i_ready  in  1` — downstream accepts output when `o_valid & i_ready`.
- `o_last  out  1` — `i_last` delayed with its beat.
- `o_out0  out  LANES*DW` — per-lane scaled difference s.
- `o_out1  out  LANES*DW` — per-lane 2^s or s.
- `o_sum  out  ACC_W` — row sum of all lanes' `o_out1`.
- `o_sum_valid  out  1` — one-cycle pulse; `o_sum` is valid.

Behaviour:
- **Reset.** While `i_rst_n` = 0 at a clock edge, all of the following clear, including mid-stall:
  - every pipeline register and captured mode bit;
  - `o_valid`, `o_last`, `o_out0`, `o_out1`, `o_sum`, `o_sum_valid`;
  - the row accumulator.
- **`o_ready`.** `o_ready = i_rst_n & i_en & ~(o_valid & ~i_ready)`.
- **Advance and stall.** The pipeline advances only when `i_en=1` and it is not stalled. It is stalled when `o_valid & ~i_ready`; all stages then hold, giving no bubble collapse, loss or duplication.
- **Latency.** 3 cycles from accept to `o_valid`. Throughput is one beat per cycle when `i_ready=1`.
- **Mode capture.** `i_sel_mult`, `i_sel_mux` and `i_last` are captured with the beat at S1 and travel with it. Mode may change on any beat.
- **S1 (subtract).**
  - `xs` = `i_in0` lane saturated to DW (clamp to 0x7FFF/0x8000 at defaults).
  - `d = xs - m`, computed at DW+1 bits, saturated to DW.
- **S2 (scale).**
  - If mult: `s = (d*LOG2E) >>> FRAC`, with a full-width product, arithmetic (floor) shift, saturated to DW.
  - Else `s = d`.
- **S3 (pow2).**
  - `n = s >>> FRAC` (floor); `f = s[FRAC-1:0]`; `mant = 2^FRAC + f`.
  - If `n >= 0`: `mant << n`, saturated to DW max positive.
  - If `0 < -n < DW`: `mant >> -n` (truncate).
  - If `-n >= DW`: result 0.
  - `o_out0 = s`; `o_out1` = pow2 if mux else s.
- **Accumulator.**
  - On each output accept, `acc += sign-extended sum of all LANES o_out1`, saturating at the ACC_W signed limits.
  - If the accepted beat has `o_last=1`: on the next edge `o_sum` = final value and `o_sum_valid=1` for exactly one cycle, independent of `i_ready`. The accumulator then restarts from 0, so the next beat's contribution is not merged with the completed row.
- **`i_en=0`.** Freezes the pipeline and accumulator, and `o_sum_valid` deasserts. Outputs hold their values.

Test Plan:
1. **Difference and pow2, no scaling.** mult=0, mux=1, all lanes:
   - `in0=0x00000800`, `in1=0x0400` -> `o_out0=0x0400`, `o_out1=0x0800`.
   - `in0=0x00000000`, `in1=0x0400` -> `o_out0=0xFC00`, `o_out1=0x0200`.
   - Each appears 3 cycles after accept.
2. **LOG2E scaling.** mult=1, mux=1:
   - `in0=0x1000`, `in1=0x1000` -> `o_out0=0x0000`, `o_out1=0x0400`.
   - `in0=0x0800`, `in1=0x0C00` -> `o_out0=0xFA3B`, `o_out1=0x018E`.
   - Alternating modes per beat must each yield these values.
3. **Saturation.** mult=0, mux=1, `in0=0x00100000`, `in1=0x8000` -> `o_out0=0x7FFF`, `o_out1=0x7FFF`. Separately, `s=0x8000` (`in0=0xFFFF8000`, `in1=0x0000`) -> `o_out1=0x0000`.
4. **Backpressure.** Issue 6 consecutive beats with `i_ready=0` for 5 cycles from first `o_valid`:
   - `o_ready` drops the cycle `o_valid` is 1 and `i_ready` is 0.
   - After release, all 6 beats emerge in order, none duplicated or dropped.
5. **Row sum.** mux=1, d=0 on all lanes, 3 beats with `i_last` on the 3rd -> one-cycle `o_sum_valid` with `o_sum=0x00003000` the cycle after the 3rd output accept. A following 1-beat row gives `o_sum=0x00001000`.
6. **Reset mid-stall.** Hold `i_rst_n=0` for one edge while stalled -> all outputs 0 and `o_ready=0` during reset. After release, `o_ready=1` and old data never reappears.
